// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch front end. It walks a byte PC through the instruction
//   memory eight bytes (one instruction pair) at a time and parks the
//   returning pairs in a 2-entry FIFO that feeds decode with a valid/ready
//   handshake. Execute can redirect the stream at any time, which flushes
//   everything queued or in flight.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   pc               : byte address to the fetch memory (sampled every edge)
//   inst1, inst2     : memory read data for pc+0..3 / pc+4..7 of last cycle
//   redirect_valid   : redirect request from execute
//   redirect_pc      : redirect target (low 3 bits ignored)
//   dec_valid        : pair available to decode
//   dec_ready        : decode accepts the pair this cycle
//   dec_inst1/2      : older / younger instruction of the head pair
//   dec_pc           : byte address of dec_inst1
module fetch_sequencer #(
  parameter int MEM_BYTES = 128,
  parameter int PC_W      = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     inst1,
  input  logic [31:0]     inst2,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_inst1,
  output logic [31:0]     dec_inst2,
  output logic [PC_W-1:0] dec_pc
);

  typedef struct packed {
    logic [31:0]     i1;
    logic [31:0]     i2;
    logic [PC_W-1:0] pc;
  } pair_t;

  localparam logic [PC_W:0] MEM_SZ = (PC_W+1)'(MEM_BYTES);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  pair_t           fifo_q [2];

  logic            pop, push, issue;
  logic [2:0]      occ;
  logic [PC_W:0]   pc_inc, pc_tgt;
  pair_t           head;

  assign pc   = pc_q;
  assign pop  = dec_valid & dec_ready;
  // Occupancy once everything already committed lands: queued pairs plus the
  // read in flight, minus what decode takes now. Issuing only below 2 is what
  // guarantees a returning read always finds a free slot.
  assign occ   = {1'b0, count_q} + {2'b00, req_q} - {2'b00, pop};
  assign issue = (occ < 3'd2) && !redirect_valid;
  // A redirect kills the read returning this cycle.
  assign push  = req_q && !redirect_valid;

  always_comb begin
    pc_inc = {1'b0, pc_q} + (PC_W+1)'(8);
    if (pc_inc >= MEM_SZ) pc_inc = pc_inc - MEM_SZ;
  end

  assign pc_tgt = {1'b0, redirect_pc[PC_W-1:3], 3'b000} % MEM_SZ;

  always_comb begin
    pc_d     = pc_q;
    req_d    = 1'b0;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      // A pop in this cycle still counts as delivered; decode flushes it.
      pc_d     = pc_tgt[PC_W-1:0];
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (issue) begin
        req_d    = 1'b1;
        req_pc_d = pc_q;
        pc_d     = pc_inc[PC_W-1:0];
      end
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      req_q    <= 1'b0;
      req_pc_q <= '0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_q    <= req_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= '{i1: inst1, i2: inst2, pc: req_pc_q};
  end

  assign head      = fifo_q[rd_ptr_q];
  assign dec_valid = (count_q != 2'd0);
  assign dec_inst1 = dec_valid ? head.i1 : '0;
  assign dec_inst2 = dec_valid ? head.i2 : '0;
  assign dec_pc    = dec_valid ? head.pc : '0;

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[2:0], pc_inc[PC_W], pc_tgt[PC_W]};

endmodule
